seg7_scan_driver: RTL and testbench

- Consumes the packed 4*DIGITS-bit display word produced by the ALU display packing logic (nibble i = digit i, nibble 0 = rightmost).
- Time-multiplexes the word onto a common-anode 7-segment display.
- Latches the word once per frame so a scan never mixes old and new values.
- Decodes each nibble to hex glyphs, with per-digit blanking and decimal-point control.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_scan_driver_if.sv | 34 +++
 rtl/seg7_hex_decoder.sv | 13 +
 rtl/seg7_scan_driver.sv | 107 ++++++++++
 tb/tb_seg7_scan_driver.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment scan driver.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark
  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0-F; lower-case b and d keep them distinct from 8 and 0
  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the display packing logic and the scan driver.
//   bcd         packed nibbles, digit i = bcd[4i+3:4i]
//   blank       1 = digit i dark
//   dp_in       1 = decimal point of digit i lit
//   anodes      active-low digit enables
//   segments    active-low cathodes {g..a}
//   dp          active-low decimal point
//   frame_start one-clock pulse when a new frame is latched
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 8
);
  import seg7_pkg::*;

  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   anodes;
  seg_t                segments;
  logic                dp;
  logic                frame_start;

  // Producer of display data; observes the panel drive
  modport master (
    output bcd, blank, dp_in,
    input  anodes, segments, dp, frame_start
  );

  // The scan driver itself
  modport slave (
    input  bcd, blank, dp_in,
    output anodes, segments, dp, frame_start
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low hex glyph decoder.
//   nibble_i  4-bit value
//   seg_c_o   active-low segments {g..a}
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_c_o
);

  assign seg_c_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver. A prescaler sets the dwell
// per digit; the display word is latched once per frame so a scan never mixes
// old and new data. Outputs are registered and lag the digit index by 1 clk.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    slave side of seg7_scan_driver_if (data in, panel drive out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned COUNT_MAX = 49999,
  parameter int unsigned DIGITS    = 8
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned CNT_BITS = $clog2(COUNT_MAX + 1);
  localparam int unsigned CNT_W    = (CNT_BITS > 0) ? CNT_BITS : 1;
  localparam int unsigned IDX_BITS = $clog2(DIGITS);
  localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][3:0]      sh_bcd_q, sh_bcd_d;
  logic [DIGITS-1:0]           sh_blank_q, sh_blank_d;
  logic [DIGITS-1:0]           sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]           anodes_q, anodes_d;
  seg_t                        seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic                        fs_q, fs_d;

  logic                        tick_c;
  logic                        wrap_c;
  seg_t                        glyph_c;

  assign tick_c = (cnt_q == CNT_W'(COUNT_MAX));
  assign wrap_c = tick_c && (idx_q == IDX_W'(DIGITS - 1));

  seg7_hex_decoder u_dec (
    .nibble_i (sh_bcd_q[idx_q]),
    .seg_c_o  (glyph_c)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_bcd_q   <= '0;
      sh_blank_q <= '0;
      sh_dp_q    <= '0;
      anodes_q   <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_bcd_q   <= sh_bcd_d;
      sh_blank_q <= sh_blank_d;
      sh_dp_q    <= sh_dp_d;
      anodes_q   <= anodes_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  // Prescaler, digit index, frame latch and output decode
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    sh_bcd_d   = sh_bcd_q;
    sh_blank_d = sh_blank_q;
    sh_dp_d    = sh_dp_q;
    anodes_d   = '1;
    seg_d      = SEG_BLANK;
    dp_d       = 1'b1;
    fs_d       = wrap_c;

    if (tick_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Capture only at the end of the last digit so the next scan is coherent
    if (wrap_c) begin
      sh_bcd_d   = bus.bcd;
      sh_blank_d = bus.blank;
      sh_dp_d    = bus.dp_in;
    end

    // Blanked digits keep every anode off, so at most one anode is ever low
    if (!sh_blank_q[idx_q]) begin
      anodes_d = ~(DIGITS'(1) << idx_q);
      seg_d    = glyph_c;
      dp_d     = ~sh_dp_q[idx_q];
    end
  end

  assign bus.anodes      = anodes_q;
  assign bus.segments    = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int CM   = 3;
  localparam int D    = 8;
  localparam int HOLD = CM + 1;
  localparam int P    = HOLD * D;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic reset;

  seg7_scan_driver_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(.COUNT_MAX(CM), .DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset release, plus the frame snapshot it implies
  int          m_k;
  logic [31:0] m_bcd;
  logic [7:0]  m_blank, m_dp;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;

  function automatic int slot(input int k);
    return ((k - 1) / HOLD) % D;
  endfunction

  function automatic logic [7:0] f_an(input int k, input logic [7:0] bl);
    int s = slot(k);
    if (bl[s]) return 8'hFF;
    return ~(8'h01 << s);
  endfunction

  function automatic logic [6:0] f_seg(input int k, input logic [31:0] b, input logic [7:0] bl);
    int s = slot(k);
    logic [31:0] t;
    if (bl[s]) return 7'h7F;
    t = b >> (4 * s);
    return GLYPH[t[3:0]];
  endfunction

  function automatic logic f_dp(input int k, input logic [7:0] d, input logic [7:0] bl);
    int s = slot(k);
    if (bl[s]) return 1'b1;
    return ~d[s];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k     <= 0;
      m_bcd   <= '0;
      m_blank <= '0;
      m_dp    <= '0;
      e_an    <= 8'hFF;
      e_seg   <= 7'h7F;
      e_dp    <= 1'b1;
      e_fs    <= 1'b0;
    end else begin
      e_an  <= f_an(m_k + 1, m_blank);
      e_seg <= f_seg(m_k + 1, m_bcd, m_blank);
      e_dp  <= f_dp(m_k + 1, m_dp, m_blank);
      e_fs  <= ((m_k + 1) % P) == 0;
      if (((m_k + 1) % P) == 0) begin
        m_bcd   <= bus.bcd;
        m_blank <= bus.blank;
        m_dp    <= bus.dp_in;
      end
      m_k <= m_k + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("anodes", 32'(bus.anodes), 32'(e_an));
    check("segments", 32'(bus.segments), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check("one_anode_max", 32'($countones(~bus.anodes) <= 1), 32'd1);
  end

  task automatic tick_to(input int k);
    int guard = 0;
    while (m_k < k) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        check("tick_to_timeout", 32'(m_k), 32'(k));
        return;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.bcd     = 32'h0;
    bus.blank   = 8'h00;
    bus.dp_in   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(bus.anodes), 32'hFF);
    check("reset_seg", 32'(bus.segments), 32'h7F);
    check("reset_fs", 32'(bus.frame_start), 32'h0);
    reset = 1'b0;

    // Walk through the first frame of zeros
    tick_to(1);
    check("k1_an", 32'(bus.anodes), 32'hFE);
    check("k1_seg", 32'(bus.segments), 32'h40);
    check("k1_dp", 32'(bus.dp), 32'h1);
    tick_to(5);
    check("k5_an", 32'(bus.anodes), 32'hFD);
    tick_to(10);
    bus.bcd = 32'h8765_4321;
    tick_to(31);
    check("k31_an", 32'(bus.anodes), 32'h7F);
    check("k31_seg_old", 32'(bus.segments), 32'h40);
    tick_to(32);
    check("k32_fs", 32'(bus.frame_start), 32'h1);
    tick_to(33);
    check("k33_fs", 32'(bus.frame_start), 32'h0);
    check("k33_an", 32'(bus.anodes), 32'hFE);
    check("k33_seg1", 32'(bus.segments), 32'h79);

    tick_to(40);
    bus.bcd = 32'hFEDC_BA98;
    tick_to(45);
    check("k45_an", 32'(bus.anodes), 32'hF7);
    check("k45_seg4", 32'(bus.segments), 32'h19);
    tick_to(61);
    check("k61_an", 32'(bus.anodes), 32'h7F);
    check("k61_seg8", 32'(bus.segments), 32'h00);

    tick_to(69);
    check("k69_seg9", 32'(bus.segments), 32'h10);
    tick_to(73);
    check("k73_segA", 32'(bus.segments), 32'h08);
    tick_to(80);
    bus.bcd = 32'h0;
    tick_to(93);
    check("k93_an", 32'(bus.anodes), 32'h7F);
    check("k93_segF", 32'(bus.segments), 32'h0E);

    // Blanking of upper six digits
    tick_to(100);
    bus.blank = 8'b1111_1100;
    bus.bcd   = 32'h0000_0042;
    tick_to(129);
    check("k129_an", 32'(bus.anodes), 32'hFE);
    check("k129_seg2", 32'(bus.segments), 32'h24);
    tick_to(133);
    check("k133_an", 32'(bus.anodes), 32'hFD);
    check("k133_seg4", 32'(bus.segments), 32'h19);
    tick_to(137);
    check("k137_an", 32'(bus.anodes), 32'hFF);
    check("k137_seg", 32'(bus.segments), 32'h7F);
    check("k137_dp", 32'(bus.dp), 32'h1);

    // Decimal point on digit 2
    tick_to(140);
    bus.blank = 8'h00;
    bus.dp_in = 8'h04;
    tick_to(165);
    check("k165_dp", 32'(bus.dp), 32'h1);
    tick_to(169);
    check("k169_an", 32'(bus.anodes), 32'hFB);
    check("k169_dp", 32'(bus.dp), 32'h0);

    // Asynchronous reset in the middle of digit 5
    tick_to(170);
    bus.bcd = 32'h1111_1111;
    tick_to(182);
    check("k182_an", 32'(bus.anodes), 32'hDF);
    #2 reset = 1'b1;
    #1;
    check("async_an", 32'(bus.anodes), 32'hFF);
    check("async_seg", 32'(bus.segments), 32'h7F);
    check("async_dp", 32'(bus.dp), 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick_to(1);
    check("rel_an", 32'(bus.anodes), 32'hFE);
    check("rel_seg0", 32'(bus.segments), 32'h40);
    tick_to(33);
    check("rel_k33_seg1", 32'(bus.segments), 32'h79);

    // Assorted inputs changing at arbitrary points, checked by the model
    for (int i = 0; i < 6; i++) begin
      tick_to(m_k + 7 + 3 * i);
      bus.bcd   = $urandom;
      bus.blank = 8'($urandom_range(0, 255));
      bus.dp_in = 8'($urandom_range(0, 255));
    end
    tick_to(m_k + 2 * P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
